// File: rtl/filter_decimator.sv
// Averages groups of 2**DECIM_LOG2 input samples into one 8-bit result.
// Results go through a first-word-fall-through FIFO; if the FIFO is full the result is dropped and overflow sets.
module filter_decimator #(
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_LOG2  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [FIFO_LOG2:0]   fifo_level,
    output logic                 overflow,
    input  logic                 clear_ovf
);
    localparam int AW    = 8 + DECIM_LOG2;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] LVL_ONE = 1;

    logic [AW-1:0]         acc;
    logic [AW-1:0]         sum;
    logic [DECIM_LOG2-1:0] cnt;
    logic [7:0]            result;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  push_ok;
    logic [7:0]            mem [DEPTH];
    logic [FIFO_LOG2-1:0]  wr_ptr;
    logic [FIFO_LOG2-1:0]  rd_ptr;
    logic [FIFO_LOG2-1:0]  nxt_rd;

    always_comb begin
        sum     = acc + {{DECIM_LOG2{1'b0}}, in_data};
        result  = sum[AW-1:DECIM_LOG2];
        push    = in_valid & (&cnt);
        pop     = out_valid & out_ready;
        full    = fifo_level[FIFO_LOG2];
        // A pop in the same cycle frees the slot the push needs.
        push_ok = push & (~full | pop);
        nxt_rd  = rd_ptr + 1'b1;
    end

    assign out_valid = (fifo_level != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            if (&cnt) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= result;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= nxt_rd;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // Head register: bypass the new result when it becomes the head.
            if (push_ok && (fifo_level == '0 || (pop && fifo_level == LVL_ONE))) begin
                out_data <= result;
            end else if (pop && fifo_level > LVL_ONE) begin
                out_data <= mem[nxt_rd];
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
